trigger_bank_ctrl: RTL and testbench
====================================

TRIGGER_BANK_CTRL -- requirements
Module: trigger_bank_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of trigger slots (power of two, >=2).
REQ-002 Parameter PRICE_W, default 8, price width in bits.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clock rising edge.
REQ-005 cfg_valid  input  1  configuration write request.
REQ-006 cfg_ready  output  1  configuration write accepted when high with cfg_valid.
REQ-007 cfg_slot  input  log2(NUM_SLOTS)  slot index to write.
REQ-008 cfg_arm  input  1  1 = arm slot with the fields below; 0 = disarm slot.
REQ-009 cfg_side  input  1  0 = bid, 1 = ask.
REQ-010 cfg_direction  input  1  0 = less aggressive, 1 = more aggressive.
REQ-011 cfg_price  input  PRICE_W  trigger reference price.
REQ-012 mkt_valid  input  1  new market snapshot offered.
REQ-013 mkt_ready  output  1  snapshot accepted when high with mkt_valid.
REQ-014 bid_price  input  PRICE_W  market highest bid.
REQ-015 ask_price  input  PRICE_W  market lowest ask.
REQ-016 fire_valid  output  1  a slot's trigger is satisfied.
REQ-017 fire_ready  input  1  downstream accepts the fire event.
REQ-018 fire_slot  output  log2(NUM_SLOTS)  index of the firing slot.
REQ-019 fire_price  output  PRICE_W  snapshot market price of the firing slot's side.
REQ-020 busy  output  1  high whenever the FSM is not in IDLE.
REQ-021 fire_count  output  8  count of completed fire handshakes.

Function
REQ-022 Per-slot state: armed, side, direction, price.
REQ-023 FSM states: IDLE, SCAN, FIRE.
REQ-024 cfg_ready and mkt_ready are high in IDLE only and combinationally low in SCAN and FIRE.
REQ-025 A config handshake updates the addressed slot on that edge, effective the next cycle; cfg_arm=0 clears armed and leaves the other fields unchanged.
REQ-026 A market handshake latches bid_price/ask_price into a snapshot, sets scan index to 0, and moves IDLE->SCAN.
REQ-027 A simultaneous config and market handshake in IDLE applies both; the scan sees the new slot contents.
REQ-028 Satisfaction uses strict comparison: bid/more: bid>price; bid/less: bid<price; ask/more: ask<price; ask/less: ask>price; equality never satisfies.
REQ-029 SCAN evaluates exactly one slot (the current index) per cycle against the snapshot.
REQ-030 In SCAN, if the slot is armed and satisfied, the FSM moves to FIRE with fire_slot=index and fire_price=snapshot bid (side 0) or ask (side 1).
REQ-031 In SCAN, if the slot is not armed or not satisfied, the index increments; at index NUM_SLOTS-1 the FSM returns to IDLE.
REQ-032 fire_valid is high only in FIRE; fire_slot and fire_price are held stable until fire_ready.
REQ-033 On a fire handshake, the slot is disarmed (one-shot) and fire_count increments, wrapping 255->0.
REQ-034 After a fire handshake, the FSM goes to IDLE if the index is NUM_SLOTS-1, else to SCAN at index+1.
REQ-035 Latency: with a market accept at edge T and no earlier fires, slot k is evaluated in cycle T+1+k and fire_valid rises in cycle T+2+k.
REQ-036 A snapshot is never re-evaluated; slots armed after IDLE is left are not seen until the next snapshot.
REQ-037 fire_slot/fire_price are don't-care while fire_valid is low.

Reset
REQ-038 Reset puts the FSM in IDLE, disarms all slots, and zeroes slot fields, snapshot, index and fire_count.
REQ-039 Outputs after reset: fire_valid=0, fire_slot=0, fire_price=0, busy=0, cfg_ready=1, mkt_ready=1.
REQ-040 Reset overrides all handshakes in the same cycle, including mid-SCAN or mid-FIRE; a pending fire is dropped without disarm-count side effects.

Verification
REQ-041 Arm slot 2 bid/more/100; snapshot bid=101 -> fire_valid in 4th cycle after accept, fire_slot=2, fire_price=101, fire_count=1, slot 2 disarmed.
REQ-042 Arm slot 0 ask/less/50; snapshot ask=50 -> no fire, busy for 4 cycles, back to IDLE.
REQ-043 Arm slots 1 and 3 bid/less/80; bid=70; fire_ready low 5 cycles -> slot 1 is held stable, then slot 3 fires; both are disarmed; a second bid=70 produces no fire.
REQ-044 Config and market handshake in the same cycle arming slot 0 ask/more/60, ask=59 -> slot 0 fires on that snapshot.
REQ-045 Reset asserted while fire_valid=1 -> next cycle fire_valid=0, IDLE, all slots disarmed, fire_count=0.
REQ-046 256 fire handshakes -> fire_count wraps to 0.

Source files
------------

// File: rtl/trigger_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// trigger_bank_ctrl_if
//
// Purpose:
//   Bundles the configuration, market-snapshot and fire handshakes of the
//   trigger bank controller, plus its status outputs, into one interface.
//
// Signal summary (directions as seen from the controller, i.e. the slave):
//   cfg_valid      in   configuration write request
//   cfg_ready      out  configuration write accepted when high with cfg_valid
//   cfg_slot       in   slot index to write
//   cfg_arm        in   1 = arm slot with the fields below, 0 = disarm slot
//   cfg_side       in   0 = bid, 1 = ask
//   cfg_direction  in   0 = less aggressive, 1 = more aggressive
//   cfg_price      in   trigger reference price
//   mkt_valid      in   new market snapshot offered
//   mkt_ready      out  snapshot accepted when high with mkt_valid
//   bid_price      in   market highest bid
//   ask_price      in   market lowest ask
//   fire_valid     out  a slot's trigger is satisfied
//   fire_ready     in   downstream accepts the fire event
//   fire_slot      out  index of the firing slot
//   fire_price     out  snapshot price of the firing slot's side
//   busy           out  controller is not idle
//   fire_count     out  count of completed fire handshakes (wraps at 256)
//
// Modports:
//   master  - the environment driving configuration / market / fire_ready
//   slave   - the controller
// ---------------------------------------------------------------------------
interface trigger_bank_ctrl_if #(
    parameter int NUM_SLOTS = 4,
    parameter int PRICE_W   = 8
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    // Configuration channel
    logic               cfg_valid;
    logic               cfg_ready;
    logic [SLOT_W-1:0]  cfg_slot;
    logic               cfg_arm;
    logic               cfg_side;
    logic               cfg_direction;
    logic [PRICE_W-1:0] cfg_price;

    // Market snapshot channel
    logic               mkt_valid;
    logic               mkt_ready;
    logic [PRICE_W-1:0] bid_price;
    logic [PRICE_W-1:0] ask_price;

    // Fire event channel
    logic               fire_valid;
    logic               fire_ready;
    logic [SLOT_W-1:0]  fire_slot;
    logic [PRICE_W-1:0] fire_price;

    // Status
    logic               busy;
    logic [7:0]         fire_count;

    modport master (
        output cfg_valid, cfg_slot, cfg_arm, cfg_side, cfg_direction, cfg_price,
        input  cfg_ready,
        output mkt_valid, bid_price, ask_price,
        input  mkt_ready,
        input  fire_valid, fire_slot, fire_price,
        output fire_ready,
        input  busy, fire_count
    );

    modport slave (
        input  cfg_valid, cfg_slot, cfg_arm, cfg_side, cfg_direction, cfg_price,
        output cfg_ready,
        input  mkt_valid, bid_price, ask_price,
        output mkt_ready,
        output fire_valid, fire_slot, fire_price,
        input  fire_ready,
        output busy, fire_count
    );
endinterface

// File: rtl/trigger_bank_ctrl.sv
// ---------------------------------------------------------------------------
// trigger_bank_ctrl
//
// Purpose:
//   Holds NUM_SLOTS one-shot price triggers. Each accepted market snapshot is
//   scanned slot by slot (one slot per cycle, ascending index). An armed slot
//   whose condition holds against the snapshot raises a fire event; when the
//   event is accepted the slot disarms itself and the fire counter advances.
//
//   Trigger condition (strict, equality never fires):
//     bid side, more aggressive : snapshot bid >  price
//     bid side, less aggressive : snapshot bid <  price
//     ask side, more aggressive : snapshot ask <  price
//     ask side, less aggressive : snapshot ask >  price
//
// Ports:
//   clock  in   sole clock, rising edge
//   reset  in   synchronous active-high reset
//   bus    slave modport of trigger_bank_ctrl_if (cfg / mkt / fire channels,
//               busy and fire_count status)
//
// Configuration and market snapshots are accepted only while idle. A
// configuration write and a snapshot in the same idle cycle are both taken,
// and the scan sees the freshly written slot.
// ---------------------------------------------------------------------------
module trigger_bank_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int PRICE_W   = 8
) (
    input logic                clock,
    input logic                reset,
    trigger_bank_ctrl_if.slave bus
);
    localparam int                SLOT_W   = $clog2(NUM_SLOTS);
    localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FIRE
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [SLOT_W-1:0]    idx_q, idx_d;

    logic [NUM_SLOTS-1:0] armed_q, armed_d;
    logic [NUM_SLOTS-1:0] side_q, side_d;
    logic [NUM_SLOTS-1:0] dir_q, dir_d;
    logic [PRICE_W-1:0]   price_q [NUM_SLOTS];
    logic [PRICE_W-1:0]   price_d [NUM_SLOTS];

    logic [PRICE_W-1:0]   snap_bid_q, snap_bid_d;
    logic [PRICE_W-1:0]   snap_ask_q, snap_ask_d;
    logic [PRICE_W-1:0]   fire_price_q, fire_price_d;
    logic [7:0]           fire_count_q, fire_count_d;

    // -----------------------------------------------------------------------
    // Trigger condition for one slot against the latched snapshot
    // -----------------------------------------------------------------------
    function automatic logic is_satisfied(
        input logic               side,
        input logic               dir,
        input logic [PRICE_W-1:0] ref_price,
        input logic [PRICE_W-1:0] bid,
        input logic [PRICE_W-1:0] ask
    );
        logic hit;
        case ({side, dir})
            2'b01:   hit = (bid > ref_price);
            2'b00:   hit = (bid < ref_price);
            2'b11:   hit = (ask < ref_price);
            default: hit = (ask > ref_price);
        endcase
        return hit;
    endfunction

    // -----------------------------------------------------------------------
    // Handshakes and the current scan decision
    // -----------------------------------------------------------------------
    logic idle;
    logic cfg_hs;
    logic mkt_hs;
    logic fire_hs;
    logic cur_hit;
    logic last_slot;

    assign idle      = (state_q == ST_IDLE);
    assign cfg_hs    = idle && bus.cfg_valid;
    assign mkt_hs    = idle && bus.mkt_valid;
    assign fire_hs   = (state_q == ST_FIRE) && bus.fire_ready;
    assign last_slot = (idx_q == LAST_IDX);
    assign cur_hit   = armed_q[idx_q] &&
                       is_satisfied(side_q[idx_q], dir_q[idx_q], price_q[idx_q],
                                    snap_bid_q, snap_ask_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        armed_d      = armed_q;
        side_d       = side_q;
        dir_d        = dir_q;
        price_d      = price_q;
        snap_bid_d   = snap_bid_q;
        snap_ask_d   = snap_ask_q;
        fire_price_d = fire_price_q;
        fire_count_d = fire_count_q;

        case (state_q)
            ST_IDLE: begin
                // Disarm keeps side/direction/price so only the armed bit moves.
                if (cfg_hs) begin
                    armed_d[bus.cfg_slot] = bus.cfg_arm;
                    if (bus.cfg_arm) begin
                        side_d[bus.cfg_slot]  = bus.cfg_side;
                        dir_d[bus.cfg_slot]   = bus.cfg_direction;
                        price_d[bus.cfg_slot] = bus.cfg_price;
                    end
                end
                if (mkt_hs) begin
                    snap_bid_d = bus.bid_price;
                    snap_ask_d = bus.ask_price;
                    idx_d      = '0;
                    state_d    = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (cur_hit) begin
                    // Capture the price once so it stays stable through FIRE.
                    fire_price_d = side_q[idx_q] ? snap_ask_q : snap_bid_q;
                    state_d      = ST_FIRE;
                end else if (last_slot) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + SLOT_W'(1);
                end
            end

            ST_FIRE: begin
                if (fire_hs) begin
                    armed_d[idx_q] = 1'b0;
                    fire_count_d   = fire_count_q + 8'd1;
                    if (last_slot) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + SLOT_W'(1);
                        state_d = ST_SCAN;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the slot table is reset on purpose; a power-up slot must
            // never look armed, so this small array lives in flops, not RAM.
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            armed_q      <= '0;
            side_q       <= '0;
            dir_q        <= '0;
            price_q      <= '{default: '0};
            snap_bid_q   <= '0;
            snap_ask_q   <= '0;
            fire_price_q <= '0;
            fire_count_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            armed_q      <= armed_d;
            side_q       <= side_d;
            dir_q        <= dir_d;
            price_q      <= price_d;
            snap_bid_q   <= snap_bid_d;
            snap_ask_q   <= snap_ask_d;
            fire_price_q <= fire_price_d;
            fire_count_q <= fire_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The scan index does not move while in FIRE, so it doubles as fire_slot.
    assign bus.cfg_ready  = idle;
    assign bus.mkt_ready  = idle;
    assign bus.fire_valid = (state_q == ST_FIRE);
    assign bus.fire_slot  = idx_q;
    assign bus.fire_price = fire_price_q;
    assign bus.busy       = !idle;
    assign bus.fire_count = fire_count_q;

endmodule

// File: tb/tb_trigger_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trigger_bank_ctrl
//
// Self-checking bench for trigger_bank_ctrl. A behavioural model of the slot
// table decides which slots fire for each snapshot; the bench then walks the
// expected cycle timeline (one cycle per slot, plus the FIRE cycles it holds)
// and compares the DUT outputs at every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_trigger_bank_ctrl;
    localparam int NUM_SLOTS = 4;
    localparam int PRICE_W   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    trigger_bank_ctrl_if #(.NUM_SLOTS(NUM_SLOTS), .PRICE_W(PRICE_W)) bus ();

    trigger_bank_ctrl #(.NUM_SLOTS(NUM_SLOTS), .PRICE_W(PRICE_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping and checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: the slot table as plain arrays
    // -----------------------------------------------------------------------
    bit         m_armed [NUM_SLOTS];
    bit         m_side  [NUM_SLOTS];
    bit         m_dir   [NUM_SLOTS];
    int         m_price [NUM_SLOTS];
    logic [7:0] m_count;

    function automatic void model_reset();
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_armed[i] = 0;
            m_side[i]  = 0;
            m_dir[i]   = 0;
            m_price[i] = 0;
        end
        m_count = 8'd0;
    endfunction

    function automatic void model_cfg(int slot, bit arm, bit side, bit dir, int price);
        m_armed[slot] = arm;
        if (arm) begin
            m_side[slot]  = side;
            m_dir[slot]   = dir;
            m_price[slot] = price;
        end
    endfunction

    // Price of the slot's side in the snapshot.
    function automatic int model_mkt(int k, int bid, int ask);
        return m_side[k] ? ask : bid;
    endfunction

    // A more aggressive bid is a higher one; a more aggressive ask is a lower one.
    function automatic bit model_hit(int k, int bid, int ask);
        int mkt;
        if (!m_armed[k]) return 0;
        mkt = model_mkt(k, bid, ask);
        if (mkt == m_price[k]) return 0;
        if (m_side[k] == 0) return m_dir[k] ? (mkt > m_price[k]) : (mkt < m_price[k]);
        return m_dir[k] ? (mkt < m_price[k]) : (mkt > m_price[k]);
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus helpers (all start and end just after a falling edge)
    // -----------------------------------------------------------------------
    task automatic idle_inputs();
        bus.cfg_valid     = 1'b0;
        bus.cfg_slot      = '0;
        bus.cfg_arm       = 1'b0;
        bus.cfg_side      = 1'b0;
        bus.cfg_direction = 1'b0;
        bus.cfg_price     = '0;
        bus.mkt_valid     = 1'b0;
        bus.bid_price     = '0;
        bus.ask_price     = '0;
        bus.fire_ready    = 1'b0;
    endtask

    task automatic drive_cfg(int slot, bit arm, bit side, bit dir, int price);
        bus.cfg_valid     = 1'b1;
        bus.cfg_slot      = 2'(slot);
        bus.cfg_arm       = arm;
        bus.cfg_side      = side;
        bus.cfg_direction = dir;
        bus.cfg_price     = 8'(price);
    endtask

    task automatic cfg_write(int slot, bit arm, bit side, bit dir, int price);
        check("cfg_ready_idle", bus.cfg_ready, 1);
        drive_cfg(slot, arm, side, dir, price);
        @(negedge clock);
        bus.cfg_valid = 1'b0;
        model_cfg(slot, arm, side, dir, price);
    endtask

    // Offer one snapshot (optionally with a same-cycle config write) and
    // follow the whole scan. hold < 0 picks a random fire_ready delay per fire.
    task automatic run_snapshot(input bit with_cfg, input int slot, input bit arm,
                                input bit side, input bit dir, input int price,
                                input int bid, input int ask, input int hold);
        bit hit;
        int d;
        int exp_price;
        check("mkt_ready_idle", bus.mkt_ready, 1);
        bus.mkt_valid = 1'b1;
        bus.bid_price = 8'(bid);
        bus.ask_price = 8'(ask);
        if (with_cfg) drive_cfg(slot, arm, side, dir, price);
        @(negedge clock);
        bus.mkt_valid = 1'b0;
        bus.bid_price = 8'($urandom_range(0, 255));
        bus.ask_price = 8'($urandom_range(0, 255));
        if (with_cfg) model_cfg(slot, arm, side, dir, price);
        // Config attempts during the scan must be refused and never seen.
        drive_cfg($urandom_range(0, NUM_SLOTS - 1), 1'b1, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 255));
        bus.mkt_valid = 1'b1;

        for (int k = 0; k < NUM_SLOTS; k++) begin
            check("scan_busy", bus.busy, 1);
            check("scan_fire_valid", bus.fire_valid, 0);
            check("scan_cfg_ready", bus.cfg_ready, 0);
            check("scan_mkt_ready", bus.mkt_ready, 0);
            hit = model_hit(k, bid, ask);
            @(negedge clock);
            if (hit) begin
                exp_price = model_mkt(k, bid, ask);
                check("fire_valid", bus.fire_valid, 1);
                check("fire_slot", bus.fire_slot, k);
                check("fire_price", bus.fire_price, exp_price);
                d = (hold < 0) ? $urandom_range(0, 3) : hold;
                repeat (d) begin
                    @(negedge clock);
                    check("hold_fire_valid", bus.fire_valid, 1);
                    check("hold_fire_slot", bus.fire_slot, k);
                    check("hold_fire_price", bus.fire_price, exp_price);
                end
                bus.fire_ready = 1'b1;
                @(negedge clock);
                bus.fire_ready = 1'b0;
                m_armed[k] = 0;
                m_count    = m_count + 8'd1;
            end
        end

        check("end_busy", bus.busy, 0);
        check("end_fire_valid", bus.fire_valid, 0);
        check("end_cfg_ready", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b0;
        bus.mkt_valid = 1'b0;
        check("fire_count", bus.fire_count, m_count);
    endtask

    task automatic snap(int bid, int ask, int hold);
        run_snapshot(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, bid, ask, hold);
    endtask

    task automatic check_reset_outputs();
        check("rst_fire_valid", bus.fire_valid, 0);
        check("rst_fire_slot", bus.fire_slot, 0);
        check("rst_fire_price", bus.fire_price, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_mkt_ready", bus.mkt_ready, 1);
        check("rst_fire_count", bus.fire_count, 0);
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        bit seen;

        idle_inputs();
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_outputs();

        // Single bid/more fire on slot 2, then confirm the slot is one-shot.
        cfg_write(2, 1'b1, 1'b0, 1'b1, 100);
        snap(101, 200, 0);
        snap(101, 200, 0);

        // Equality never fires: ask/less at 50 vs ask 50.
        cfg_write(0, 1'b1, 1'b1, 1'b0, 50);
        snap(0, 50, 0);

        // Two bid/less fires with a long downstream stall, then nothing left.
        cfg_write(1, 1'b1, 1'b0, 1'b0, 80);
        cfg_write(3, 1'b1, 1'b0, 1'b0, 80);
        snap(70, 50, 5);
        snap(70, 50, 0);

        // Same-cycle config and snapshot: the scan sees the new slot 0.
        run_snapshot(1'b1, 0, 1'b1, 1'b1, 1'b1, 60, 0, 59, 0);

        // Randomised traffic with prices clustered around the references.
        for (int it = 0; it < 40; it++) begin
            int nwr;
            nwr = $urandom_range(0, 3);
            for (int w = 0; w < nwr; w++) begin
                cfg_write($urandom_range(0, NUM_SLOTS - 1), ($urandom_range(0, 3) != 0),
                          1'($urandom), 1'($urandom), $urandom_range(40, 60));
            end
            if ($urandom_range(0, 3) == 0) begin
                run_snapshot(1'b1, $urandom_range(0, NUM_SLOTS - 1), 1'b1, 1'($urandom),
                             1'($urandom), $urandom_range(40, 60),
                             $urandom_range(35, 65), $urandom_range(35, 65), -1);
            end else begin
                snap($urandom_range(35, 65), $urandom_range(35, 65), -1);
            end
        end

        // Reset while a fire is pending: dropped, table cleared, count zeroed.
        for (int i = 0; i < NUM_SLOTS; i++) cfg_write(i, 1'b0, 1'b0, 1'b0, 0);
        cfg_write(1, 1'b1, 1'b0, 1'b1, 10);
        if (m_count == 8'd0) begin
            snap(200, 0, 0);
            cfg_write(1, 1'b1, 1'b0, 1'b1, 10);
        end
        bus.mkt_valid = 1'b1;
        bus.bid_price = 8'd200;
        bus.ask_price = 8'd0;
        @(negedge clock);
        bus.mkt_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.fire_valid) seen = 1;
            else @(negedge clock);
        end
        check("pre_reset_fire_seen", seen, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_reset_outputs();
        snap(200, 0, 0);

        // 256 fire handshakes wrap the counter back to zero.
        for (int it = 0; it < 64; it++) begin
            for (int k = 0; k < NUM_SLOTS; k++) cfg_write(k, 1'b1, 1'b0, 1'b1, 0);
            snap(1, 255, 0);
            if (it == 62) check("count_252", bus.fire_count, 252);
        end
        check("count_wrap", bus.fire_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
